// File: rtl/adma_chn_sched.sv
// rtl/adma_chn_sched.sv - per-channel DMA transfer scheduler: priority arbitration with round-robin tie-break
// Optional watchdog abort in WAIT is built when ADMA_SCHED_WDOG_EN is defined.
module adma_chn_sched #(
  parameter int CHN_NUM  = 4,
  parameter int CHN_ID_W = 2,
  parameter int PRIO_W   = 2,
  parameter int WDOG_CYC = 4096
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [CHN_NUM-1:0]         chn_req_i,
  input  logic [CHN_NUM*PRIO_W-1:0]  chn_prio_i,
  output logic                       eng_start_o,
  output logic [CHN_ID_W-1:0]        eng_chn_id_o,
  input  logic                       eng_start_rdy_i,
  input  logic                       eng_done_i,
  input  logic                       eng_err_i,
  output logic [CHN_NUM-1:0]         chn_busy_o,
  output logic [CHN_NUM-1:0]         chn_done_o,
  output logic [CHN_NUM-1:0]         chn_err_o,
  output logic                       sched_busy_o
);

  typedef enum logic [1:0] {IDLE, ARB, ISSUE, WAIT} state_t;

  state_t                state;
  logic [CHN_ID_W-1:0]   rr_ptr;
  logic [CHN_NUM-1:0]    elig;
  logic                  win_vld;
  logic [CHN_ID_W-1:0]   win_id;
  logic [PRIO_W-1:0]     win_prio;
  logic [CHN_ID_W:0]     idx;
  logic [CHN_ID_W-1:0]   cid;

`ifdef ADMA_SCHED_WDOG_EN
  localparam int WDOG_W = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;
  logic [WDOG_W-1:0]     wdog_cnt;
`else
  localparam int unused_wdog_cyc = WDOG_CYC;
`endif

  assign elig = chn_req_i & ~chn_busy_o;

  // Scan from rr_ptr; a strict '>' keeps the first channel in scan order on ties.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    win_prio = '0;
    idx      = '0;
    cid      = '0;
    for (int k = 0; k < CHN_NUM; k++) begin
      idx = {1'b0, rr_ptr} + (CHN_ID_W+1)'(k);
      if (idx >= (CHN_ID_W+1)'(CHN_NUM))
        idx = idx - (CHN_ID_W+1)'(CHN_NUM);
      cid = idx[CHN_ID_W-1:0];
      if (elig[cid] && (!win_vld || chn_prio_i[cid*PRIO_W +: PRIO_W] > win_prio)) begin
        win_vld  = 1'b1;
        win_id   = cid;
        win_prio = chn_prio_i[cid*PRIO_W +: PRIO_W];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      eng_start_o  <= 1'b0;
      eng_chn_id_o <= '0;
      chn_busy_o   <= '0;
      chn_done_o   <= '0;
      chn_err_o    <= '0;
      sched_busy_o <= 1'b0;
`ifdef ADMA_SCHED_WDOG_EN
      wdog_cnt     <= '0;
`endif
    end else begin
      chn_done_o <= '0;
      chn_err_o  <= '0;
      case (state)
        IDLE: begin
          if (|elig) begin
            state        <= ARB;
            sched_busy_o <= 1'b1;
          end
        end
        ARB: begin
          if (win_vld) begin
            eng_chn_id_o <= win_id;
            chn_busy_o   <= CHN_NUM'(1) << win_id;
            eng_start_o  <= 1'b1;
            state        <= ISSUE;
          end else begin
            state        <= IDLE;
            sched_busy_o <= 1'b0;
          end
        end
        ISSUE: begin
          if (eng_start_rdy_i) begin
            eng_start_o <= 1'b0;
            rr_ptr      <= (eng_chn_id_o == CHN_ID_W'(CHN_NUM-1)) ? '0 : eng_chn_id_o + 1'b1;
            state       <= WAIT;
`ifdef ADMA_SCHED_WDOG_EN
            wdog_cnt    <= '0;
`endif
          end
        end
        WAIT: begin
          if (eng_done_i) begin
            if (eng_err_i) chn_err_o  <= chn_busy_o;
            else           chn_done_o <= chn_busy_o;
            chn_busy_o   <= '0;
            sched_busy_o <= 1'b0;
            state        <= IDLE;
          end
`ifdef ADMA_SCHED_WDOG_EN
          // Abort a hung transfer; a late done lands outside WAIT and is dropped.
          else if (wdog_cnt == WDOG_W'(WDOG_CYC-1)) begin
            chn_err_o    <= chn_busy_o;
            chn_busy_o   <= '0;
            sched_busy_o <= 1'b0;
            state        <= IDLE;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adma_chn_sched.sv
// tb/tb_adma_chn_sched.sv - self-checking bench for adma_chn_sched against a priority/round-robin model
module tb_adma_chn_sched;
  localparam int N  = 4;
  localparam int PW = 2;

  logic         aclk;
  logic         aresetn;
  logic [N-1:0] req;
  logic [N*PW-1:0] prio;
  logic         eng_start_o;
  logic [1:0]   eng_chn_id_o;
  logic         rdy;
  logic         done;
  logic         err;
  logic [N-1:0] chn_busy_o;
  logic [N-1:0] chn_done_o;
  logic [N-1:0] chn_err_o;
  logic         sched_busy_o;

  int n_chk  = 0;
  int n_fail = 0;
  int rr     = 0;
  int cur_id = 0;

`ifdef ADMA_SCHED_WDOG_EN
  adma_chn_sched #(.CHN_NUM(N), .CHN_ID_W(2), .PRIO_W(PW), .WDOG_CYC(16)) dut (
`else
  adma_chn_sched #(.CHN_NUM(N), .CHN_ID_W(2), .PRIO_W(PW)) dut (
`endif
    .aclk(aclk), .aresetn(aresetn), .chn_req_i(req), .chn_prio_i(prio),
    .eng_start_o(eng_start_o), .eng_chn_id_o(eng_chn_id_o), .eng_start_rdy_i(rdy),
    .eng_done_i(done), .eng_err_i(err), .chn_busy_o(chn_busy_o),
    .chn_done_o(chn_done_o), .chn_err_o(chn_err_o), .sched_busy_o(sched_busy_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 300000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Winner = highest priority, ties broken by distance from the round-robin pointer.
  function automatic int pick(input logic [N-1:0] r, input logic [N*PW-1:0] p, input int ptr);
    int best = -1;
    int bkey = -1;
    for (int i = 0; i < N; i++) begin
      int d, key;
      if (!r[i]) continue;
      d   = (i - ptr + N) % N;
      key = int'(p[i*PW +: PW]) * N + (N - 1 - d);
      if (key > bkey) begin bkey = key; best = i; end
    end
    return best;
  endfunction

  task automatic grant_and_accept(input int exp_id, input int rdy_wait, input bit perturb);
    int n;
    for (n = 1; n <= 20; n++) begin
      @(negedge aclk);
      if (n == 1) check("pulse_clear", 32'(chn_done_o | chn_err_o), 0);
      if (eng_start_o) break;
    end
    check("start_latency", n, 2);
    check("grant_id", 32'(eng_chn_id_o), exp_id);
    check("busy_onehot", 32'(chn_busy_o), 1 << exp_id);
    check("sched_busy", 32'(sched_busy_o), 1);
    for (int k = 0; k < rdy_wait; k++) begin
      if (perturb) begin req = N'($urandom); prio = (N*PW)'($urandom); end
      @(negedge aclk);
      check("bp_start", 32'(eng_start_o), 1);
      check("bp_id", 32'(eng_chn_id_o), exp_id);
    end
    rdy = 1'b1;
    @(negedge aclk);
    rdy = 1'b0;
    check("start_drop", 32'(eng_start_o), 0);
    check("wait_busy", 32'(chn_busy_o), 1 << exp_id);
    cur_id = exp_id;
    rr = (exp_id + 1) % N;
  endtask

  task automatic finish_xfer(input bit e, input int dwait, input logic [N-1:0] nreq, input logic [N*PW-1:0] nprio);
    for (int k = 0; k < dwait; k++) begin
      err = 1'($urandom);
      rdy = 1'($urandom);
      @(negedge aclk);
      check("no_early_pulse", 32'(chn_done_o | chn_err_o), 0);
    end
    done = 1'b1; err = e; rdy = 1'b0; req = nreq; prio = nprio;
    @(negedge aclk);
    done = 1'b0; err = 1'b0;
    check("done_vec", 32'(chn_done_o), e ? 0 : (1 << cur_id));
    check("err_vec", 32'(chn_err_o), e ? (1 << cur_id) : 0);
    check("busy_clear", 32'(chn_busy_o), 0);
    check("sched_idle", 32'(sched_busy_o), 0);
  endtask

  initial begin
    int ids[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] nreq;
    logic [N*PW-1:0] nprio;
    int exp_id;

    aresetn = 1'b0; req = '0; prio = '0; rdy = 1'b0; done = 1'b0; err = 1'b0;
    repeat (3) @(negedge aclk);
    check("rst_start", 32'(eng_start_o), 0);
    check("rst_id", 32'(eng_chn_id_o), 0);
    check("rst_busy", 32'(chn_busy_o), 0);
    check("rst_done", 32'(chn_done_o | chn_err_o), 0);
    check("rst_sched", 32'(sched_busy_o), 0);
    aresetn = 1'b1;

    // Single request on channel 2.
    req = 4'b0100; prio = '0;
    grant_and_accept(2, 0, 1'b0);
    finish_xfer(1'b0, 4, 4'b0000, '0);

    // Stray done while idle must not produce a pulse.
    @(negedge aclk); done = 1'b1;
    @(negedge aclk); done = 1'b0;
    check("stray_done", 32'(chn_done_o | chn_err_o), 0);
    check("stray_sched", 32'(sched_busy_o), 0);

    // Priority wins over round-robin position.
    req = 4'b1011; prio = 8'b11_01_01_01;
    grant_and_accept(3, 0, 1'b0);
    finish_xfer(1'b0, 1, 4'b1111, '0);

    // Equal priorities rotate.
    for (int i = 0; i < 5; i++) begin
      grant_and_accept(ids[i], 1, 1'b0);
      finish_xfer(1'b0, 0, (i == 4) ? 4'b0010 : 4'b1111, '0);
    end

    // Long backpressure, then error completion.
    grant_and_accept(1, 10, 1'b0);
    finish_xfer(1'b1, 2, 4'b1111, '0);

    // Reset during WAIT loses the transfer and the pointer.
    grant_and_accept(2, 1, 1'b0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("arst_start", 32'(eng_start_o), 0);
    check("arst_busy", 32'(chn_busy_o), 0);
    check("arst_sched", 32'(sched_busy_o), 0);
    check("arst_pulse", 32'(chn_done_o | chn_err_o), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    rr = 0;
    grant_and_accept(0, 0, 1'b0);
    nreq = N'($urandom_range(1, (1 << N) - 1));
    nprio = (N*PW)'($urandom);
    finish_xfer(1'b0, 1, nreq, nprio);

    // Randomised traffic against the model.
    for (int r = 0; r < 40; r++) begin
      exp_id = pick(nreq, nprio, rr);
      grant_and_accept(exp_id, int'($urandom_range(0, 3)), 1'b1);
      nreq  = (r == 39) ? '0 : N'($urandom_range(1, (1 << N) - 1));
      nprio = (N*PW)'($urandom);
      finish_xfer(1'($urandom), int'($urandom_range(0, 4)), nreq, nprio);
    end

`ifdef ADMA_SCHED_WDOG_EN
    begin
      int n;
      req = 4'b0100; prio = '0;
      grant_and_accept(2, 0, 1'b0);
      req = '0;
      for (n = 1; n <= 40; n++) begin
        @(negedge aclk);
        if (chn_err_o != 0) break;
      end
      check("wdog_latency", n, 16);
      check("wdog_err", 32'(chn_err_o), 4'b0100);
      check("wdog_busy", 32'(chn_busy_o), 0);
      done = 1'b1;
      @(negedge aclk);
      done = 1'b0;
      @(negedge aclk);
      check("wdog_late_done", 32'(chn_done_o | chn_err_o), 0);
    end
`endif

    repeat (3) @(negedge aclk);
    check("final_idle", 32'(sched_busy_o), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adma_chn_sched.md
Name: adma_chn_sched

Overview:
- Per-channel transfer scheduler for the AXI DMA.
- Takes level start requests from the DMA configuration register bank, one per destination channel.
- Arbitrates among them by programmable priority, round-robin on ties, and issues exactly one channel at a time to the shared DMA transfer engine.
- Returns per-channel done/error pulses to the status register bank.

Parameters:
- CHN_NUM, 4, number of DMA destination channels (2..16)
- CHN_ID_W, 2, channel id width; must equal $clog2(CHN_NUM)
- PRIO_W, 2, per-channel priority width; larger value = higher priority
- WDOG_CYC, 4096, watchdog limit in cycles; used only with the optional feature

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- chn_req_i  in  CHN_NUM  level start request per channel, from config regs
- chn_prio_i  in  CHN_NUM*PRIO_W  priority of channel i at bits [i*PRIO_W +: PRIO_W]
- eng_start_o  out  1  start valid to the transfer engine
- eng_chn_id_o  out  CHN_ID_W  channel id qualified by eng_start_o
- eng_start_rdy_i  in  1  engine accepts start (handshake when valid & rdy)
- eng_done_i  in  1  single-cycle completion pulse from the engine
- eng_err_i  in  1  error flag, sampled only with eng_done_i
- chn_busy_o  out  CHN_NUM  one-hot, currently granted channel
- chn_done_o  out  CHN_NUM  one-cycle pulse on successful completion
- chn_err_o  out  CHN_NUM  one-cycle pulse on error or abort
- sched_busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, FSM = IDLE, round-robin pointer rr_ptr = 0.
- Reset asserted mid-transfer returns to IDLE immediately. No done/err pulse is emitted for the lost transfer.
- States: IDLE, ARB, ISSUE, WAIT.
- IDLE: if any eligible request exists, go to ARB next cycle. Eligible = chn_req_i[i] & ~chn_busy_o[i].
- ARB (exactly 1 cycle):
  - Pick the eligible channel with the highest chn_prio_i.
  - On ties, pick the first channel found scanning i = rr_ptr, rr_ptr+1, ... modulo CHN_NUM.
  - Register the winner into eng_chn_id_o and set chn_busy_o[winner].
  - Go to ISSUE.
  - If no eligible request remains (requests dropped), return to IDLE with no grant.
- ISSUE:
  - eng_start_o = 1; eng_chn_id_o held stable.
  - Wait for eng_start_rdy_i. On the handshake cycle: eng_start_o drops the next cycle, rr_ptr = winner+1 (wrapping to 0 after CHN_NUM-1), go to WAIT.
  - Deassertion of chn_req_i here is ignored; the transfer proceeds.
- WAIT: on eng_done_i:
  - Pulse chn_done_o[id] if eng_err_i = 0, else pulse chn_err_o[id]; the pulse lands the cycle after eng_done_i.
  - Clear chn_busy_o and go to IDLE.
- Latency:
  - Request to eng_start_o = 2 cycles (IDLE→ARB→ISSUE).
  - done/err pulse coincides with the IDLE cycle.
  - A request still asserted is re-arbitrated from IDLE, so back-to-back grants are separated by a minimum of 3 idle-engine cycles.
- Protocol errors:
  - eng_done_i outside WAIT is ignored.
  - eng_start_rdy_i outside ISSUE is ignored.
- Simultaneous events: eng_done_i in the same cycle as a new request → the done is processed first. The new request is seen in IDLE on the following cycle.
- Priority change during ISSUE/WAIT has no effect on the current grant.
- Every priority read is a registered-input-free combinational compare inside ARB. The priority compare is CHN_NUM-way; no arithmetic overflow is possible (rr_ptr wrap is explicit).

Optional Feature:
- Macro: ADMA_SCHED_WDOG_EN.
- Defined:
  - A counter runs in WAIT. On reaching WDOG_CYC-1 without eng_done_i, the block aborts: pulse chn_err_o[id], clear busy, go to IDLE.
  - A late eng_done_i for the aborted transfer is ignored.
  - The counter clears on entering WAIT.
- Undefined: no counter is built; WAIT lasts indefinitely until eng_done_i.

Test Plan:
- Single request: chn_req_i=4'b0100, prio all 0, rdy tied 1 → eng_start_o high 2 cycles after request with id=2. Done pulse 5 cycles later → chn_done_o=4'b0100 for 1 cycle.
- Priority: chn_req_i=4'b1011, prio ch3=3, others=1 → first grant id=3.
- Round-robin: all four requests held, equal prio, error-free done each time → grant order 0,1,2,3,0.
- Backpressure and error: rdy held 0 for 10 cycles → eng_start_o and id stable throughout. Done with eng_err_i=1 → chn_err_o pulse; chn_done_o stays 0.
- Reset mid-op: assert aresetn=0 during WAIT → all outputs 0 asynchronously. After release, a held request is granted again with rr_ptr=0.
- Watchdog: with ADMA_SCHED_WDOG_EN and WDOG_CYC=16, no eng_done_i → chn_err_o pulses 16 cycles after the handshake. A subsequent eng_done_i is ignored.
